fetch_prefetch: RTL and testbench

Parametrised instruction-fetch unit with an in-order prefetch buffer. It is the successor to the single-register fetch stage. It issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses. Fetched words and their PCs are buffered in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. A redirect (branch/jump) flushes the buffer and discards responses still in flight.

---
 rtl/fetch_prefetch.sv | 137 +++++++++++++
 tb/tb_fetch_prefetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit with an in-order prefetch FIFO. Sequential word requests are
// credit-limited so every accepted response always has a buffer slot.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam int              DEPTH_W  = DEPTH;
    localparam logic [CW:0]     DEPTH_C  = DEPTH_W[CW:0];
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [XLEN-1:0] redirect_aligned_s;
    logic            credit_s;
    logic            req_fire_s;
    logic            rsp_ok_s;
    logic            drop_s;
    logic            push_s;
    logic            pop_s;

    // In-flight discards still hold credit, so buffered plus outstanding never exceeds DEPTH.
    assign credit_s      = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C;
    assign mem_req_valid = enable & ~reset & credit_s;
    assign mem_req_addr  = fetch_pc_r;
    assign pc            = fetch_pc_r;

    assign req_fire_s = mem_req_valid & mem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok_s   = mem_rsp_valid & (outstanding_r != CNT_ZERO);
    assign drop_s     = rsp_ok_s & (discard_r != CNT_ZERO);
    assign push_s     = rsp_ok_s & ~drop_s;
    assign pop_s      = inst_valid & inst_ready;

    assign inst_valid = (count_r != CNT_ZERO);
    assign inst_data  = data_mem_r[rd_ptr_r];
    assign inst_pc    = pc_mem_r[rd_ptr_r];

    assign redirect_aligned_s = {redirect_pc[XLEN-1:2], 2'b00};

    // Outstanding request count after this cycle's fire and response.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        if (req_fire_s && !rsp_ok_s) begin
            outstanding_nxt_s = outstanding_r + CNT_ONE;
        end else if (!req_fire_s && rsp_ok_s) begin
            outstanding_nxt_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
    end

    // Fetch/response PCs, FIFO pointers and counters; redirect overrides every other update.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            rd_ptr_r      <= PTR_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_aligned_s;
                rsp_pc_r   <= redirect_aligned_s;
                rd_ptr_r   <= PTR_ZERO;
                wr_ptr_r   <= PTR_ZERO;
                count_r    <= CNT_ZERO;
                discard_r  <= outstanding_nxt_s;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (push_s && !pop_s) begin
                    count_r <= count_r + CNT_ONE;
                end else if (!push_s && pop_s) begin
                    count_r <= count_r - CNT_ONE;
                end
                if (drop_s) begin
                    discard_r <= discard_r - CNT_ONE;
                end
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= {XLEN{1'b0}};
                pc_mem_r[i]   <= {XLEN{1'b0}};
            end
        end else if (push_s && !redirect_valid) begin
            data_mem_r[wr_ptr_r] <= mem_rsp_data;
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: an in-order memory model answers requests one
// cycle later, and a monitor compares every consumed instruction against the queue.
module tb_fetch_prefetch;
    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset, enable, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid, mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            inst_valid, inst_ready;
    logic [XLEN-1:0] inst_data, inst_pc, pc;

    int checks = 0;
    int passes = 0;
    logic              mem_hold = 1'b0;
    logic [XLEN-1:0]   pend_q [$];
    logic [2*XLEN-1:0] exp_q  [$];
    logic [2*XLEN-1:0] mon_e;

    always #5 clock = ~clock;

    fetch_prefetch dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .pc             (pc)
    );

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic expect_seq(input logic [XLEN-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mem_word(start + 32'(4 * i)), start + 32'(4 * i)});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        smp();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; enable = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; mem_hold = 1'b0;
        tick();
        tick();
        smp();
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset_pc", pc, 32'h0);
        check("reset_inst_data", inst_data, 32'h0);
        check("reset_inst_pc", inst_pc, 32'h0);
    endtask

    // Memory model: capture fired requests, answer them in order one cycle later.
    always @(negedge clock) begin
        if (mem_req_valid && mem_req_ready) pend_q.push_back(mem_req_addr);
    end

    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        forever begin
            @(posedge clock);
            #2;
            if (!mem_hold && pend_q.size() > 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(pend_q.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'h0;
            end
        end
    end

    // Monitor: every consumed head must match the next expected entry.
    always @(negedge clock) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_inst: got pc %h data %h, required no output", inst_pc, inst_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", inst_pc, mon_e[XLEN-1:0]);
                check("inst_data", inst_data, mon_e[2*XLEN-1:XLEN]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b1; inst_ready = 1'b0;

        // Linear fetch: addresses stream every cycle, first output two cycles after release.
        do_reset();
        expect_seq(32'h0, 6);
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b1;
        smp(); check("lin_addr0", mem_req_addr, 32'h0); check("lin_valid_c0", 32'(inst_valid), 32'd0);
        tick(); smp(); check("lin_addr1", mem_req_addr, 32'h4); check("lin_valid_c1", 32'(inst_valid), 32'd0);
        tick(); smp(); check("lin_addr2", mem_req_addr, 32'h8); check("lin_valid_c2", 32'(inst_valid), 32'd1);
        tick(); tick(); tick();
        tick(); enable = 1'b0;
        drain();
        check("lin_pc_end", pc, 32'h18);

        // Decode stalled: four requests fill the FIFO, one slot freed gives one more request.
        do_reset();
        expect_seq(32'h0, 5);
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("full_req_valid", 32'(mem_req_valid), 32'd1);
            check("full_req_addr", mem_req_addr, 32'(4 * i));
            tick();
        end
        smp(); check("full_no_req_c4", 32'(mem_req_valid), 32'd0);
        tick(); smp();
        check("full_no_req_c5", 32'(mem_req_valid), 32'd0);
        check("full_head_valid", 32'(inst_valid), 32'd1);
        check("full_head_pc", inst_pc, 32'h0);
        check("full_head_data", inst_data, mem_word(32'h0));
        tick(); smp(); check("full_head_stable", inst_pc, 32'h0);
        tick(); inst_ready = 1'b1;
        tick(); inst_ready = 1'b0;
        smp(); check("full_refill_valid", 32'(mem_req_valid), 32'd1); check("full_refill_addr", mem_req_addr, 32'h10);
        tick(); enable = 1'b0; inst_ready = 1'b1;
        drain();
        check("full_pc_end", pc, 32'h14);

        // Redirect with requests 8 and 12 in flight: both dropped, fetch resumes at 0x100.
        do_reset();
        expect_seq(32'h0, 2);
        expect_seq(32'h100, 3);
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b1;
        tick(); tick();
        tick(); mem_hold = 1'b1;
        tick(); enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0; enable = 1'b1; mem_hold = 1'b0;
        smp(); check("redir_pc", pc, 32'h100); check("redir_addr", mem_req_addr, 32'h100);
        check("redir_flush", 32'(inst_valid), 32'd0);
        tick(); smp(); check("redir_drop8", 32'(inst_valid), 32'd0);
        tick(); smp(); check("redir_drop12", 32'(inst_valid), 32'd0);
        tick(); enable = 1'b0;
        smp(); check("redir_first_pc", inst_pc, 32'h100);
        drain();
        check("redir_pc_end", pc, 32'h10C);

        // Redirect coinciding with a request fire and a response arrival.
        do_reset();
        expect_seq(32'h0, 1);
        expect_seq(32'h200, 3);
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b1;
        tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        smp(); check("same_fire", 32'(mem_req_valid), 32'd1);
        tick(); redirect_valid = 1'b0;
        smp(); check("same_addr", mem_req_addr, 32'h200); check("same_flush", 32'(inst_valid), 32'd0);
        tick(); smp(); check("same_drop", 32'(inst_valid), 32'd0);
        tick(); smp(); check("same_first_pc", inst_pc, 32'h200);
        tick(); enable = 1'b0;
        drain();
        check("same_pc_end", pc, 32'h20C);

        // Fetch disabled with three outstanding: no new requests, all three delivered.
        do_reset();
        expect_seq(32'h0, 3);
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b1; mem_hold = 1'b1;
        tick(); tick();
        tick(); enable = 1'b0; mem_hold = 1'b0;
        smp(); check("dis_no_req", 32'(mem_req_valid), 32'd0); check("dis_pc", pc, 32'hC);
        tick(); smp(); check("dis_no_req2", 32'(mem_req_valid), 32'd0);
        drain();
        check("dis_pc_end", pc, 32'hC);

        // Reset mid-operation with buffered words and two stale requests in flight.
        do_reset();
        tick(); reset = 1'b0; enable = 1'b1; inst_ready = 1'b0;
        tick(); tick();
        tick(); mem_hold = 1'b1;
        tick();
        smp(); check("mid_head_pc", inst_pc, 32'h0); check("mid_no_req", 32'(mem_req_valid), 32'd0);
        tick(); reset = 1'b1; enable = 1'b0;
        tick(); reset = 1'b0; inst_ready = 1'b1; mem_hold = 1'b0;
        smp(); check("mid_rst_valid", 32'(inst_valid), 32'd0); check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_inst_pc", inst_pc, 32'h0);
        tick(); smp(); check("mid_stale1", 32'(inst_valid), 32'd0);
        tick(); smp(); check("mid_stale2", 32'(inst_valid), 32'd0);
        tick(); smp(); check("mid_stale3", 32'(inst_valid), 32'd0); check("mid_pc_end", pc, 32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
